mem_arbiter: RTL and testbench

- Shares one downstream memory port between two requesters: the instruction-fetch path (read-only) and the load/store path (read/write).
- Sits between the if/mem stages and the memory model, and replaces their direct connections to separate RAM ports.
- Single-outstanding transaction engine with valid/ready request handshakes and a registered response.
- Arbitration: fixed priority (data over fetch) by default; round-robin as a compile-time option.

---
 rtl/mem_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// This block lets the instruction-fetch path and the load/store path share
// one downstream memory port. It handles one transaction at a time. Each
// requester uses a valid/ready handshake, and each response is registered.
//
// Arbitration:
//   - Default build: fixed priority, with the data port winning over fetch.
//   - With MEM_ARB_RR_EN defined: round-robin. When both requesters are
//     valid, the grant goes to the one that was not granted last.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_if_req_valid         fetch request
//   o_if_req_ready         fetch request accepted this cycle
//   i_if_addr              fetch address (4-byte aligned)
//   o_if_resp_valid        fetch data valid (one-cycle pulse)
//   o_if_rdata             32-bit instruction selected by latched addr[2]
//   i_mem_req_valid        data request
//   o_mem_req_ready        data request accepted this cycle
//   i_mem_addr             data address
//   i_mem_wr_ena           1 = write, 0 = read
//   i_mem_wr_data          write data
//   i_mem_byte_enable      write byte lanes
//   o_mem_resp_valid       read data / write ack (one-cycle pulse)
//   o_mem_rdata            read data, 0 for writes
//   o_bus_req_valid        downstream request
//   i_bus_req_ready        downstream accepts
//   o_bus_addr             latched address
//   o_bus_wr_ena           latched write flag (0 for fetch)
//   o_bus_wr_data          latched write data (0 for fetch)
//   o_bus_byte_enable      latched byte lanes (0 for fetch)
//   i_bus_resp_valid       downstream response
//   i_bus_rdata            downstream read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req_valid,
  output logic              o_if_req_ready,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_resp_valid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_mem_req_valid,
  output logic              o_mem_req_ready,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic              i_mem_wr_ena,
  input  logic [DATA_W-1:0] i_mem_wr_data,
  input  logic [7:0]        i_mem_byte_enable,
  output logic              o_mem_resp_valid,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_bus_req_valid,
  input  logic              i_bus_req_ready,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic              o_bus_wr_ena,
  output logic [DATA_W-1:0] o_bus_wr_data,
  output logic [7:0]        o_bus_byte_enable,
  input  logic              i_bus_resp_valid,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_addr2;
  logic [ADDR_W-1:0] r_bus_addr;
  logic              r_bus_wr_ena;
  logic [DATA_W-1:0] r_bus_wr_data;
  logic [7:0]        r_bus_byte_enable;
  logic              r_if_resp_valid;
  logic [31:0]       r_if_rdata;
  logic              r_mem_resp_valid;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              w_grant_if;
  logic              w_grant_mem;
  logic              w_resp_done;

  // Grant selection. A grant can only be given while the engine is idle.
  always_comb begin
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    if (r_state == ST_IDLE) begin
`ifdef MEM_ARB_RR_EN
      // On a tie, the grant goes to whichever side did not win last time.
      if (i_mem_req_valid && i_if_req_valid) begin
        if (r_last_grant == OWN_IF) begin
          w_grant_mem = 1'b1;
        end else begin
          w_grant_if  = 1'b1;
        end
      end else begin
        w_grant_mem = i_mem_req_valid;
        w_grant_if  = i_if_req_valid;
      end
`else
      w_grant_mem = i_mem_req_valid;
      w_grant_if  = i_if_req_valid & ~i_mem_req_valid;
`endif
    end else begin
      w_grant_if  = 1'b0;
      w_grant_mem = 1'b0;
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> WAIT transaction sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_mem || w_grant_if) begin
          w_state_next = ST_ISSUE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (i_bus_req_ready) begin
          w_state_next = ST_WAIT;
        end else begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (i_bus_resp_valid) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // A bus response only counts while waiting; in IDLE or ISSUE it is dropped.
  assign w_resp_done = (r_state == ST_WAIT) && i_bus_resp_valid;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request payload latch, owner ID and arbitration history, all captured on acceptance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant      <= OWN_IF;
      r_owner           <= OWN_IF;
      r_addr2           <= 1'b0;
      r_bus_addr        <= {ADDR_W{1'b0}};
      r_bus_wr_ena      <= 1'b0;
      r_bus_wr_data     <= {DATA_W{1'b0}};
      r_bus_byte_enable <= 8'h00;
    end else if (w_grant_mem) begin
      r_last_grant      <= OWN_MEM;
      r_owner           <= OWN_MEM;
      r_addr2           <= 1'b0;
      r_bus_addr        <= i_mem_addr;
      r_bus_wr_ena      <= i_mem_wr_ena;
      r_bus_wr_data     <= i_mem_wr_data;
      r_bus_byte_enable <= i_mem_byte_enable;
    end else if (w_grant_if) begin
      // A fetch is always a read, so the write payload is cleared.
      r_last_grant      <= OWN_IF;
      r_owner           <= OWN_IF;
      r_addr2           <= i_if_addr[2];
      r_bus_addr        <= i_if_addr;
      r_bus_wr_ena      <= 1'b0;
      r_bus_wr_data     <= {DATA_W{1'b0}};
      r_bus_byte_enable <= 8'h00;
    end else begin
      r_last_grant      <= r_last_grant;
      r_owner           <= r_owner;
      r_addr2           <= r_addr2;
      r_bus_addr        <= r_bus_addr;
      r_bus_wr_ena      <= r_bus_wr_ena;
      r_bus_wr_data     <= r_bus_wr_data;
      r_bus_byte_enable <= r_bus_byte_enable;
    end
  end

  // Response pulses and read-data capture. Only the owner's registers update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_if_resp_valid  <= 1'b0;
      r_if_rdata       <= 32'h0000_0000;
      r_mem_resp_valid <= 1'b0;
      r_mem_rdata      <= {DATA_W{1'b0}};
    end else begin
      r_if_resp_valid  <= w_resp_done && (r_owner == OWN_IF);
      r_mem_resp_valid <= w_resp_done && (r_owner == OWN_MEM);
      if (w_resp_done && (r_owner == OWN_IF)) begin
        r_if_rdata <= r_addr2 ? i_bus_rdata[63:32] : i_bus_rdata[31:0];
      end else begin
        r_if_rdata <= r_if_rdata;
      end
      // For a write, the ack carries zero data.
      if (w_resp_done && (r_owner == OWN_MEM)) begin
        r_mem_rdata <= r_bus_wr_ena ? {DATA_W{1'b0}} : i_bus_rdata;
      end else begin
        r_mem_rdata <= r_mem_rdata;
      end
    end
  end

  assign o_if_req_ready    = w_grant_if;
  assign o_mem_req_ready   = w_grant_mem;
  assign o_bus_req_valid   = (r_state == ST_ISSUE);
  assign o_bus_addr        = r_bus_addr;
  assign o_bus_wr_ena      = r_bus_wr_ena;
  assign o_bus_wr_data     = r_bus_wr_data;
  assign o_bus_byte_enable = r_bus_byte_enable;
  assign o_if_resp_valid   = r_if_resp_valid;
  assign o_if_rdata        = r_if_rdata;
  assign o_mem_resp_valid  = r_mem_resp_valid;
  assign o_mem_rdata       = r_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter.
//   - Each accepted request pushes its expected response into a queue:
//     owner, data, acceptance cycle and latency.
//   - Each response pulse pops one entry and compares against it.
//   - A small bus responder model sits in the same process. It supports a
//     programmable ready-wait and response delay.
//   - Inputs change 1 time unit after the rising edge; outputs are sampled
//     on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_if_req_valid;
  logic        o_if_req_ready;
  logic [63:0] i_if_addr;
  logic        o_if_resp_valid;
  logic [31:0] o_if_rdata;
  logic        i_mem_req_valid;
  logic        o_mem_req_ready;
  logic [63:0] i_mem_addr;
  logic        i_mem_wr_ena;
  logic [63:0] i_mem_wr_data;
  logic [7:0]  i_mem_byte_enable;
  logic        o_mem_resp_valid;
  logic [63:0] o_mem_rdata;
  logic        o_bus_req_valid;
  logic        i_bus_req_ready;
  logic [63:0] o_bus_addr;
  logic        o_bus_wr_ena;
  logic [63:0] o_bus_wr_data;
  logic [7:0]  o_bus_byte_enable;
  logic        i_bus_resp_valid;
  logic [63:0] i_bus_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_if_req_valid(i_if_req_valid), .o_if_req_ready(o_if_req_ready),
    .i_if_addr(i_if_addr), .o_if_resp_valid(o_if_resp_valid), .o_if_rdata(o_if_rdata),
    .i_mem_req_valid(i_mem_req_valid), .o_mem_req_ready(o_mem_req_ready),
    .i_mem_addr(i_mem_addr), .i_mem_wr_ena(i_mem_wr_ena), .i_mem_wr_data(i_mem_wr_data),
    .i_mem_byte_enable(i_mem_byte_enable), .o_mem_resp_valid(o_mem_resp_valid),
    .o_mem_rdata(o_mem_rdata), .o_bus_req_valid(o_bus_req_valid),
    .i_bus_req_ready(i_bus_req_ready), .o_bus_addr(o_bus_addr), .o_bus_wr_ena(o_bus_wr_ena),
    .o_bus_wr_data(o_bus_wr_data), .o_bus_byte_enable(o_bus_byte_enable),
    .i_bus_resp_valid(i_bus_resp_valid), .i_bus_rdata(i_bus_rdata)
  );

  typedef struct {
    bit          is_mem;
    logic [63:0] data;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  bit          grants[$];
  int          acc_cyc[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          ready_wait = 0;
  int          resp_delay = 0;
  int          wait_cnt   = 0;
  int          resp_cnt   = 0;
  int          issue_cnt  = 0;
  bit          ovr_en = 1'b0;
  logic [63:0] ovr_data = 64'h0;
  logic [63:0] resp_data = 64'h0;
  logic [63:0] exp_addr = 64'h0;
  logic [63:0] exp_wd = 64'h0;
  bit          exp_we = 1'b0;
  logic [7:0]  exp_be = 8'h00;
  logic [31:0] hold_if = 32'h0;
  logic [63:0] hold_mem = 64'h0;
  bit          acc_if = 1'b0;
  bit          acc_mem = 1'b0;

  // Count one comparison; report it if it does not match.
  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Contents of the memory model at a given address.
  function automatic logic [63:0] model_data(input logic [63:0] addr);
    if (ovr_en) return ovr_data;
    return {addr[31:0] ^ 32'h5A5A_0F0F, ~addr[31:0]};
  endfunction

  // Falling-edge observation: acceptances, bus payload, response pulses.
  task automatic monitor();
    exp_t        e;
    logic [63:0] md;
    cyc++;
    acc_if  = 1'b0;
    acc_mem = 1'b0;
    if (o_if_req_ready && o_mem_req_ready) check_val("both_ready", 64'd1, 64'd0);
    if ((o_if_resp_valid || o_mem_resp_valid) && (i_if_req_valid || i_mem_req_valid))
      check_val("ready_with_resp", {63'd0, o_if_req_ready | o_mem_req_ready}, 64'd1);
    if (i_mem_req_valid && o_mem_req_ready) begin
      acc_mem  = 1'b1;
      e.is_mem = 1'b1;
      e.data   = i_mem_wr_ena ? 64'h0 : model_data(i_mem_addr);
      e.cyc    = cyc;
      e.lat    = 3 + ready_wait + resp_delay;
      sb.push_back(e);
      grants.push_back(1'b1);
      acc_cyc.push_back(cyc);
      exp_addr = i_mem_addr;
      exp_we   = i_mem_wr_ena;
      exp_wd   = i_mem_wr_data;
      exp_be   = i_mem_byte_enable;
    end
    if (i_if_req_valid && o_if_req_ready) begin
      acc_if   = 1'b1;
      md       = model_data(i_if_addr);
      e.is_mem = 1'b0;
      e.data   = i_if_addr[2] ? {32'h0, md[63:32]} : {32'h0, md[31:0]};
      e.cyc    = cyc;
      e.lat    = 3 + ready_wait + resp_delay;
      sb.push_back(e);
      grants.push_back(1'b0);
      acc_cyc.push_back(cyc);
      exp_addr = i_if_addr;
      exp_we   = 1'b0;
      exp_wd   = 64'h0;
      exp_be   = 8'h00;
    end
    if (o_bus_req_valid) begin
      issue_cnt++;
      check_val("bus_addr", o_bus_addr, exp_addr);
      check_val("bus_wr_ena", {63'd0, o_bus_wr_ena}, {63'd0, exp_we});
      check_val("bus_be", {56'd0, o_bus_byte_enable}, {56'd0, exp_be});
      if (exp_we) check_val("bus_wr_data", o_bus_wr_data, exp_wd);
      if (i_bus_req_ready) begin
        resp_cnt  = resp_delay + 1;
        resp_data = model_data(o_bus_addr);
      end
    end
    if (o_if_resp_valid) begin
      if (sb.size() == 0) begin
        check_val("if_resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_val("if_resp_owner", {63'd0, e.is_mem}, 64'd0);
        check_val("if_rdata", {32'h0, o_if_rdata}, e.data);
        check_val("if_latency", 64'(cyc - e.cyc), 64'(e.lat));
        check_val("mem_rdata_hold", o_mem_rdata, hold_mem);
        hold_if = e.data[31:0];
      end
    end
    if (o_mem_resp_valid) begin
      if (sb.size() == 0) begin
        check_val("mem_resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_val("mem_resp_owner", {63'd0, e.is_mem}, 64'd1);
        check_val("mem_rdata", o_mem_rdata, e.data);
        check_val("mem_latency", 64'(cyc - e.cyc), 64'(e.lat));
        check_val("if_rdata_hold", {32'h0, o_if_rdata}, {32'h0, hold_if});
        hold_mem = e.data;
      end
    end
  endtask

  // Bus responder, evaluated just after each rising edge.
  task automatic bus_model();
    i_bus_resp_valid = 1'b0;
    i_bus_rdata      = {$urandom, $urandom};
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        i_bus_resp_valid = 1'b1;
        i_bus_rdata      = resp_data;
      end
    end
    if (o_bus_req_valid) begin
      if (wait_cnt < ready_wait) begin
        i_bus_req_ready = 1'b0;
        wait_cnt++;
      end else begin
        i_bus_req_ready = 1'b1;
        wait_cnt = 0;
      end
    end else begin
      i_bus_req_ready = 1'b0;
      wait_cnt = 0;
    end
  endtask

  // Advance one cycle.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    bus_model();
  endtask

  // Present one request, hold it until accepted, then scramble the payload.
  task automatic do_req(input bit is_mem, input logic [63:0] addr, input bit we,
                        input logic [63:0] wd, input logic [7:0] be);
    int n;
    if (is_mem) begin
      i_mem_req_valid = 1'b1; i_mem_addr = addr; i_mem_wr_ena = we;
      i_mem_wr_data = wd; i_mem_byte_enable = be;
    end else begin
      i_if_req_valid = 1'b1; i_if_addr = addr;
    end
    n = 0;
    acc_if = 1'b0;
    acc_mem = 1'b0;
    while (!(is_mem ? acc_mem : acc_if) && n < 20) begin
      step();
      n++;
    end
    if (!(is_mem ? acc_mem : acc_if)) check_val("accept_timeout", 64'd0, 64'd1);
    i_mem_req_valid = 1'b0;
    i_if_req_valid  = 1'b0;
    i_if_addr = ~addr; i_mem_addr = ~addr; i_mem_wr_ena = ~we;
    i_mem_wr_data = ~wd; i_mem_byte_enable = ~be;
  endtask

  // Run until no transaction is outstanding.
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || o_bus_req_valid) && n < 60) begin
      step();
      n++;
    end
    if (sb.size() != 0) check_val("drain_timeout", 64'(sb.size()), 64'd0);
    step();
  endtask

  // Hold reset for the given number of cycles and clear the expectations.
  task automatic apply_reset(input int n);
    i_rst = 1'b1;
    sb.delete();
    hold_if = 32'h0;
    hold_mem = 64'h0;
    repeat (n) step();
    i_rst = 1'b0;
  endtask

  initial begin
    bit exp_g;
    i_rst = 1'b1; i_if_req_valid = 1'b0; i_if_addr = 64'h0; i_mem_req_valid = 1'b0;
    i_mem_addr = 64'h0; i_mem_wr_ena = 1'b0; i_mem_wr_data = 64'h0; i_mem_byte_enable = 8'h00;
    i_bus_req_ready = 1'b0; i_bus_resp_valid = 1'b0; i_bus_rdata = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset(2);
    check_val("rst_bus_valid", {63'd0, o_bus_req_valid}, 64'd0);
    check_val("rst_if_resp", {63'd0, o_if_resp_valid}, 64'd0);
    check_val("rst_mem_resp", {63'd0, o_mem_resp_valid}, 64'd0);
    check_val("rst_ready", {62'd0, o_if_req_ready, o_mem_req_ready}, 64'd0);
    check_val("rst_bus_addr", o_bus_addr, 64'h0);
    check_val("rst_bus_wdata", o_bus_wr_data, 64'h0);
    check_val("rst_bus_we_be", {55'd0, o_bus_wr_ena, o_bus_byte_enable}, 64'h0);
    check_val("rst_rdata", {32'h0, o_if_rdata} | o_mem_rdata, 64'h0);

    // Fetch of the upper instruction word.
    ovr_en = 1'b1; ovr_data = 64'h12345678_9ABCDEF0;
    do_req(1'b0, 64'h8000_0004, 1'b0, 64'h0, 8'h00);
    drain();
    check_val("fetch_rdata_hi", {32'h0, o_if_rdata}, 64'h12345678);
    ovr_en = 1'b0;

    // Write with the downstream holding off for three cycles.
    ready_wait = 3; issue_cnt = 0;
    do_req(1'b1, 64'h8000_1000, 1'b1, 64'hDEADBEEF, 8'h0F);
    drain();
    check_val("write_issue_cycles", 64'(issue_cnt), 64'd4);
    ready_wait = 0;

    // Random reads on both ports.
    for (int i = 0; i < 4; i++) begin
      do_req(i[0], {32'h8000_0000, $urandom} & ~64'h3, 1'b0, 64'h0, 8'h00);
      drain();
    end

    // A spurious response while idle.
    i_bus_resp_valid = 1'b1; i_bus_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    step(); step();
    check_val("spur_idle_resp", {62'd0, o_if_resp_valid, o_mem_resp_valid}, 64'd0);
    check_val("spur_idle_busv", {63'd0, o_bus_req_valid}, 64'd0);

    // A spurious response during ISSUE, followed by normal completion.
    ready_wait = 2;
    do_req(1'b1, 64'h8000_2040, 1'b0, 64'h0, 8'h00);
    i_bus_resp_valid = 1'b1; i_bus_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
    step();
    check_val("spur_issue_busv", {63'd0, o_bus_req_valid}, 64'd1);
    check_val("spur_issue_resp", {62'd0, o_if_resp_valid, o_mem_resp_valid}, 64'd0);
    drain();
    ready_wait = 0;

    // Reset while waiting, with the bus response arriving after the reset.
    resp_delay = 2;
    do_req(1'b0, 64'h8000_0008, 1'b0, 64'h0, 8'h00);
    step();
    check_val("wait_busv", {63'd0, o_bus_req_valid}, 64'd0);
    i_rst = 1'b1; sb.delete(); hold_if = 32'h0; hold_mem = 64'h0;
    step();
    i_rst = 1'b0;
    check_val("midrst_busv", {63'd0, o_bus_req_valid}, 64'd0);
    check_val("midrst_resp", {62'd0, o_if_resp_valid, o_mem_resp_valid}, 64'd0);
    check_val("midrst_if_rdata", {32'h0, o_if_rdata}, 64'h0);
    step(); step();
    check_val("late_resp_pulse", {62'd0, o_if_resp_valid, o_mem_resp_valid}, 64'd0);
    check_val("late_resp_busv", {63'd0, o_bus_req_valid}, 64'd0);
    resp_delay = 0;
    do_req(1'b0, 64'h8000_0010, 1'b0, 64'h0, 8'h00);
    drain();

    // Both requesters valid continuously, zero-wait bus.
    apply_reset(1);
    grants.delete(); acc_cyc.delete();
    i_mem_req_valid = 1'b1; i_mem_addr = 64'h8000_2008; i_mem_wr_ena = 1'b0;
    i_mem_wr_data = 64'h0; i_mem_byte_enable = 8'h00;
    i_if_req_valid = 1'b1; i_if_addr = 64'h8000_0020;
    for (int n = 0; n < 40 && grants.size() < 4; n++) step();
    i_mem_req_valid = 1'b0; i_if_req_valid = 1'b0;
    check_val("arb_grant_count", 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef MEM_ARB_RR_EN
      exp_g = (i % 2 == 0);
`else
      exp_g = 1'b1;
`endif
      check_val($sformatf("arb_grant%0d", i), {63'd0, grants[i]}, {63'd0, exp_g});
    end
    for (int i = 1; i < acc_cyc.size(); i++)
      check_val($sformatf("b2b_gap%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
